// File: rtl/xing_request_scheduler.sv
// ---------------------------------------------------------------------------
// xing_request_scheduler
// Front-end scheduler between the north/south pedestrian push buttons and the
// crossing controller. It detects button presses and latches one pending flag
// per side, which drives the WAIT lamps. It issues one crossing request over a
// req/ack handshake, holds off the next request for a minimum traffic-green
// interval, and keeps a saturating count of crossings served.
//
// Parameters:
//   MIN_GREEN  minimum green cycles after xing_done before the next request
//   TMR_W      width of the green-interval timer
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   NB, SB      north/south push buttons (level)
//   xing_ack    controller accepted the request (1-cycle pulse)
//   xing_done   controller back in traffic green (1-cycle pulse)
//   xing_req    crossing request (registered)
//   NW, SW      north/south WAIT lamps = pending flags (registered)
//   served_cnt  crossings accepted, saturating at 255 (registered)
//
// Build option:
//   XING_SYNC_EN  defined -> 2-flop synchronizer on each button ahead of the
//                 press-detect register (adds 2 cycles of press latency)
// ---------------------------------------------------------------------------
module xing_request_scheduler #(
    parameter int unsigned MIN_GREEN = 12,
    parameter int unsigned TMR_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       NB,
    input  logic       SB,
    input  logic       xing_ack,
    input  logic       xing_done,
    output logic       xing_req,
    output logic       NW,
    output logic       SW,
    output logic [7:0] served_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        GREEN = 2'd0,
        REQ   = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               nb_s;
    logic               sb_s;
    logic               nb_q;
    logic               sb_q;
    logic               pend_n;
    logic               pend_s;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   cnt;
    logic               req_q;

    logic               press_n_c;
    logic               press_s_c;
    logic               ack_acc_c;
    logic               done_acc_c;
    logic               timer_exp_c;
    logic               pend_n_nxt;
    logic               pend_s_nxt;
    logic [TMR_W-1:0]   timer_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               req_nxt;

`ifdef XING_SYNC_EN
    logic [1:0] nb_sync;
    logic [1:0] sb_sync;

    // Two-stage synchronizers for the asynchronous buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nb_sync <= 2'b00;
            sb_sync <= 2'b00;
        end else begin
            nb_sync <= {nb_sync[0], NB};
            sb_sync <= {sb_sync[0], SB};
        end
    end

    assign nb_s = nb_sync[1];
    assign sb_s = sb_sync[1];
`else
    assign nb_s = NB;
    assign sb_s = SB;
`endif

    // Rising-edge press detect against the previous sample.
    assign press_n_c   = nb_s & ~nb_q;
    assign press_s_c   = sb_s & ~sb_q;
    assign timer_exp_c = (timer == TMR_MAX);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GREEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            GREEN: if ((pend_n | pend_s) && timer_exp_c) state_nxt = REQ;
            REQ:   if (xing_ack)  state_nxt = BUSY;
            BUSY:  if (xing_done) state_nxt = GREEN;
            default:              state_nxt = GREEN;
        endcase
    end

    // Output / datapath next values; ack and done only act in their own state.
    always_comb begin
        ack_acc_c  = (state == REQ)  && xing_ack;
        done_acc_c = (state == BUSY) && xing_done;
        req_nxt    = (state_nxt == REQ);

        // A press on the accepting ack cycle is served by that crossing.
        pend_n_nxt = ack_acc_c ? 1'b0 : (pend_n | press_n_c);
        pend_s_nxt = ack_acc_c ? 1'b0 : (pend_s | press_s_c);

        timer_nxt = timer;
        if (done_acc_c) begin
            timer_nxt = '0;
        end else if ((state == GREEN) && !timer_exp_c) begin
            timer_nxt = timer + TMR_W'(1);
        end

        cnt_nxt = cnt;
        if (ack_acc_c && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Datapath and output registers; timer resets expired so the first
    // crossing is not delayed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nb_q   <= 1'b0;
            sb_q   <= 1'b0;
            pend_n <= 1'b0;
            pend_s <= 1'b0;
            timer  <= TMR_MAX;
            cnt    <= '0;
            req_q  <= 1'b0;
        end else begin
            nb_q   <= nb_s;
            sb_q   <= sb_s;
            pend_n <= pend_n_nxt;
            pend_s <= pend_s_nxt;
            timer  <= timer_nxt;
            cnt    <= cnt_nxt;
            req_q  <= req_nxt;
        end
    end

    assign xing_req   = req_q;
    assign NW         = pend_n;
    assign SW         = pend_s;
    assign served_cnt = cnt;

endmodule

// File: tb/tb_xing_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xing_request_scheduler
// Self-checking bench: a per-cycle vector table (inputs for one clock edge and
// the outputs expected just after it), followed by hand-written sequences for
// counter saturation and asynchronous reset in BUSY. Honors XING_SYNC_EN.
// ---------------------------------------------------------------------------
module tb_xing_request_scheduler;

    logic       clk;
    logic       reset;
    logic       NB;
    logic       SB;
    logic       xing_ack;
    logic       xing_done;
    logic       xing_req;
    logic       NW;
    logic       SW;
    logic [7:0] served_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       nb;
        logic       sb;
        logic       ack;
        logic       done;
        logic       req;
        logic       nw;
        logic       sw;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    xing_request_scheduler #(
        .MIN_GREEN (12),
        .TMR_W     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .NB         (NB),
        .SB         (SB),
        .xing_ack   (xing_ack),
        .xing_done  (xing_done),
        .xing_req   (xing_req),
        .NW         (NW),
        .SW         (SW),
        .served_cnt (served_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic nb, input logic sb, input logic ack, input logic done,
                       input logic req, input logic nw, input logic sw, input int cnt);
        vec_t v;
        v.nb = nb; v.sb = sb; v.ack = ack; v.done = done;
        v.req = req; v.nw = nw; v.sw = sw; v.cnt = 8'(cnt);
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Press NB once, wait (bounded) for the request, ack it, then finish it.
    task automatic crossing(input bit send_done);
        int n;
        NB = 1'b1;
        tick();
        NB = 1'b0;
        n = 0;
        while (!xing_req && n < 40) begin
            tick();
            n++;
        end
        chk("req_wait", int'(xing_req), 1);
        xing_ack = 1'b1;
        tick();
        xing_ack = 1'b0;
        if (send_done) begin
            tick();
            xing_done = 1'b1;
            tick();
            xing_done = 1'b0;
        end
    endtask

    initial begin
        int total;
        reset     = 1'b0;
        NB        = 1'b0;
        SB        = 1'b0;
        xing_ack  = 1'b0;
        xing_done = 1'b0;

        #3;
        chk("rst_req", int'(xing_req), 0);
        chk("rst_nw",  int'(NW), 0);
        chk("rst_sw",  int'(SW), 0);
        chk("rst_cnt", int'(served_cnt), 0);
        #9 reset = 1'b1;   // released mid-cycle; next posedge is edge 1

`ifdef XING_SYNC_EN
        // Scenario 1 through the synchronizer: lamp after edge 5, req after 6.
        add(0,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0);
        add(1,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,1,0,0);
        add(0,0,0,0, 1,1,0,0);
        add(0,0,1,0, 0,0,0,1);
        add(0,0,0,1, 0,0,0,1);
`else
        add(0,0,0,0, 0,0,0,0);                 // e1
        add(0,0,0,0, 0,0,0,0);                 // e2
        add(1,0,0,0, 0,1,0,0);                 // e3 press north
        add(0,0,0,0, 1,1,0,0);                 // e4 request
        add(0,0,0,0, 1,1,0,0);                 // e5 held
        add(0,0,1,0, 0,0,0,1);                 // e6 ack
        add(0,0,0,0, 0,0,0,1);                 // e7 BUSY
        add(0,1,0,0, 0,0,1,1);                 // e8 south press in BUSY
        add(0,1,0,0, 0,0,1,1);                 // e9 held
        add(0,0,0,1, 0,0,1,1);                 // e10 done -> timer 0
        for (int i = 11; i <= 22; i++)         // green interval, stray done/ack
            add(0,0, logic'(i == 15), logic'(i == 12), 0,0,1,1);
        add(0,0,0,0, 1,0,1,1);                 // e23 = d+13 request
        add(0,0,0,1, 1,0,1,1);                 // e24 stray done in REQ
        add(1,0,0,0, 1,1,1,1);                 // e25 north press in REQ
        add(0,1,1,1, 0,0,0,2);                 // e26 ack+done, south press absorbed
        add(0,1,0,1, 0,0,0,2);                 // e27 done
        for (int i = 28; i <= 45; i++)         // south held: no new press
            add(0,1,0,0, 0,0,0,2);
        add(0,0,0,0, 0,0,0,2);                 // e46
        add(1,0,0,0, 0,1,0,2);                 // e47 north
        add(0,0,0,0, 1,1,0,2);                 // e48 request
        add(0,1,0,0, 1,1,1,2);                 // e49 south, 2 cycles later
        add(0,0,0,0, 1,1,1,2);                 // e50
        add(0,0,1,0, 0,0,0,3);                 // e51 one ack serves both
        add(0,0,1,0, 0,0,0,3);                 // e52 stray ack in BUSY
        add(0,0,0,1, 0,0,0,3);                 // e53 done
`endif

        foreach (vecs[i]) begin
            NB        = vecs[i].nb;
            SB        = vecs[i].sb;
            xing_ack  = vecs[i].ack;
            xing_done = vecs[i].done;
            tick();
            chk($sformatf("v%0d_req", i + 1), int'(xing_req), int'(vecs[i].req));
            chk($sformatf("v%0d_nw",  i + 1), int'(NW),       int'(vecs[i].nw));
            chk($sformatf("v%0d_sw",  i + 1), int'(SW),       int'(vecs[i].sw));
            chk($sformatf("v%0d_cnt", i + 1), int'(served_cnt), int'(vecs[i].cnt));
        end
        NB = 1'b0; SB = 1'b0; xing_ack = 1'b0; xing_done = 1'b0;

        // Run up to 260 crossings in total; count saturates at 255.
        total = int'(vecs[vecs.size() - 1].cnt);
        while (total < 259) begin
            crossing(1'b1);
            total++;
            if (total == 254) chk("cnt_254", int'(served_cnt), 254);
        end
        crossing(1'b0);                        // 260th, left in BUSY
        chk("cnt_sat", int'(served_cnt), 255);
        chk("busy_req", int'(xing_req), 0);

        // Press while BUSY, then asynchronous reset between edges.
        NB = 1'b1;
        tick();
        NB = 1'b0;
        repeat (3) tick();
        chk("busy_nw", int'(NW), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_req", int'(xing_req), 0);
        chk("arst_nw",  int'(NW), 0);
        chk("arst_sw",  int'(SW), 0);
        chk("arst_cnt", int'(served_cnt), 0);
        #2 reset = 1'b1;

        // Fresh crossing right after reset must not wait for a green interval.
        crossing(1'b1);
        chk("post_cnt", int'(served_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
